// File: rtl/acsp_tx_pkg.sv
// Shared types and constants for the UART transmit stream arbiter.
package acsp_tx_pkg;

    typedef enum logic [1:0] {
        SRC_NONE = 2'd0,
        SRC_ID   = 2'd1,
        SRC_META = 2'd2,
        SRC_DATA = 2'd3
    } src_e;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        SEND    = 3'd1,
        WAIT_HI = 3'd2,
        WAIT_LO = 3'd3,
        GAP     = 3'd4
    } state_e;

    localparam logic [31:0] ID_WORD_DEFAULT = 32'h31414C53;

    // Byte idx of the SUMP ID word; idx 3 is sent first (MSB first).
    function automatic logic [7:0] id_byte(input logic [31:0] word, input logic [1:0] idx);
        return word[{idx, 3'b000} +: 8];
    endfunction

endpackage

// File: rtl/uart_byte_pacer.sv
// Paces one byte against the UART busy handshake: waits for tx_busy to rise
// (or a timeout) and then to fall, then reports done for one cycle.
module uart_byte_pacer
    import acsp_tx_pkg::*;
#(
    parameter int BUSY_TIMEOUT = 16
) (
    input  logic system_clock,
    input  logic ext_reset_n,
    input  logic soft_reset_n,
    input  logic start,
    input  logic tx_busy,
    output logic done,
    output logic timeout_err
);

    localparam int TW = $clog2(BUSY_TIMEOUT + 1);

    state_e        state_r;
    state_e        state_s;
    logic [TW-1:0] wait_cnt_r;
    logic [TW-1:0] wait_cnt_s;
    logic          err_s;

    // Next-state: wait for busy to rise (bounded), then for it to fall.
    always_comb begin
        state_s    = state_r;
        wait_cnt_s = wait_cnt_r;
        err_s      = timeout_err;
        case (state_r)
            IDLE: begin
                if (start) begin
                    state_s    = WAIT_HI;
                    wait_cnt_s = '0;
                end else begin
                    state_s = IDLE;
                end
            end
            WAIT_HI: begin
                if (tx_busy) begin
                    state_s = WAIT_LO;
                end else if (wait_cnt_r == TW'(BUSY_TIMEOUT - 1)) begin
                    state_s = WAIT_LO;
                    err_s   = 1'b1;
                end else begin
                    wait_cnt_s = wait_cnt_r + TW'(1);
                end
            end
            WAIT_LO: begin
                if (!tx_busy) begin
                    state_s = IDLE;
                end else begin
                    state_s = WAIT_LO;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // Done as soon as the transmitter is seen idle again after the byte.
    assign done = (state_r == WAIT_LO) && !tx_busy;

    // State, timeout counter and sticky error register.
    always_ff @(posedge system_clock or negedge ext_reset_n) begin
        if (!ext_reset_n) begin
            state_r     <= IDLE;
            wait_cnt_r  <= '0;
            timeout_err <= 1'b0;
        end else if (!soft_reset_n) begin
            state_r     <= IDLE;
            wait_cnt_r  <= '0;
            timeout_err <= 1'b0;
        end else begin
            state_r     <= state_s;
            wait_cnt_r  <= wait_cnt_s;
            timeout_err <= err_s;
        end
    end

endmodule

// File: rtl/tx_stream_arbiter.sv
// Shares one UART transmitter among the ID responder, metadata stream and
// sample FIFO. Fixed priority ID > META > DATA, grant held for a whole packet.
module tx_stream_arbiter
    import acsp_tx_pkg::*;
#(
    parameter logic [31:0] ID_WORD      = ID_WORD_DEFAULT,
    parameter int          BUSY_TIMEOUT = 16,
    parameter int          CNT_W        = 16
) (
    input  logic             system_clock,
    input  logic             ext_reset_n,
    input  logic             soft_reset_n,
    input  logic             send_id,
    input  logic             meta_valid,
    input  logic [7:0]       meta_data,
    input  logic             meta_last,
    output logic             meta_ready,
    input  logic             data_valid,
    input  logic [7:0]       data_data,
    input  logic             data_last,
    output logic             data_ready,
    input  logic             tx_busy,
    output logic             tx_start,
    output logic [7:0]       tx_data,
    output logic [1:0]       grant,
    output logic             arb_busy,
    output logic [CNT_W-1:0] byte_count,
    output logic             timeout_err
);

    // WAIT_HI here means "byte handed to the pacer"; the pacer tracks the
    // busy-high / busy-low phases itself.
    state_e           state_r, state_s;
    src_e             grant_r, grant_s;
    logic [1:0]       id_idx_r, id_idx_s;
    logic             last_r, last_s;
    logic             id_pending_r, id_pending_s;
    logic [CNT_W-1:0] byte_count_s;
    logic [7:0]       tx_data_s;
    logic             tx_start_s, meta_ready_s, data_ready_s;
    logic             src_valid_s, src_last_s;
    logic [7:0]       src_byte_s;
    logic             pacer_done_s;

    // Select valid/byte/last of the granted source; ID is always valid.
    always_comb begin
        src_valid_s = 1'b0;
        src_byte_s  = 8'h00;
        src_last_s  = 1'b0;
        case (grant_r)
            SRC_ID: begin
                src_valid_s = 1'b1;
                src_byte_s  = id_byte(ID_WORD, id_idx_r);
                src_last_s  = (id_idx_r == 2'd0);
            end
            SRC_META: begin
                src_valid_s = meta_valid;
                src_byte_s  = meta_data;
                src_last_s  = meta_last;
            end
            SRC_DATA: begin
                src_valid_s = data_valid;
                src_byte_s  = data_data;
                src_last_s  = data_last;
            end
            default: begin
                src_valid_s = 1'b0;
            end
        endcase
    end

    // Arbitration and packet sequencing.
    always_comb begin
        state_s      = state_r;
        grant_s      = grant_r;
        id_idx_s     = id_idx_r;
        last_s       = last_r;
        byte_count_s = byte_count;
        tx_data_s    = tx_data;
        tx_start_s   = 1'b0;
        meta_ready_s = 1'b0;
        data_ready_s = 1'b0;
        // A send_id pulse while the ID packet itself is running is dropped.
        if (send_id && (grant_r != SRC_ID)) begin
            id_pending_s = 1'b1;
        end else begin
            id_pending_s = id_pending_r;
        end
        case (state_r)
            IDLE: begin
                if (id_pending_r || send_id) begin
                    grant_s      = SRC_ID;
                    id_idx_s     = 2'd3;
                    byte_count_s = '0;
                    state_s      = SEND;
                end else if (meta_valid) begin
                    grant_s      = SRC_META;
                    byte_count_s = '0;
                    state_s      = SEND;
                end else if (data_valid) begin
                    grant_s      = SRC_DATA;
                    byte_count_s = '0;
                    state_s      = SEND;
                end else begin
                    state_s = IDLE;
                end
            end
            SEND: begin
                // Guard keeps ready strobes tied to a valid source byte.
                if (src_valid_s) begin
                    tx_start_s   = 1'b1;
                    tx_data_s    = src_byte_s;
                    meta_ready_s = (grant_r == SRC_META);
                    data_ready_s = (grant_r == SRC_DATA);
                    last_s       = src_last_s;
                    if (byte_count != {CNT_W{1'b1}}) begin
                        byte_count_s = byte_count + CNT_W'(1);
                    end else begin
                        byte_count_s = byte_count;
                    end
                    if (grant_r == SRC_ID) begin
                        id_idx_s = id_idx_r - 2'd1;
                    end else begin
                        id_idx_s = id_idx_r;
                    end
                    state_s = WAIT_HI;
                end else begin
                    state_s = GAP;
                end
            end
            WAIT_HI, WAIT_LO: begin
                if (pacer_done_s) begin
                    if (last_r) begin
                        state_s = IDLE;
                        grant_s = SRC_NONE;
                        if (grant_r == SRC_ID) begin
                            id_pending_s = 1'b0;
                        end else begin
                            id_pending_s = id_pending_r || send_id;
                        end
                    end else if (src_valid_s) begin
                        state_s = SEND;
                    end else begin
                        state_s = GAP;
                    end
                end else begin
                    state_s = state_r;
                end
            end
            GAP: begin
                if (src_valid_s) begin
                    state_s = SEND;
                end else begin
                    state_s = GAP;
                end
            end
            default: begin
                state_s = IDLE;
                grant_s = SRC_NONE;
            end
        endcase
    end

    // State and registered outputs; either reset abandons the packet.
    always_ff @(posedge system_clock or negedge ext_reset_n) begin
        if (!ext_reset_n) begin
            state_r      <= IDLE;
            grant_r      <= SRC_NONE;
            id_idx_r     <= 2'd0;
            last_r       <= 1'b0;
            id_pending_r <= 1'b0;
            byte_count   <= '0;
            tx_data      <= 8'h00;
            tx_start     <= 1'b0;
            meta_ready   <= 1'b0;
            data_ready   <= 1'b0;
            arb_busy     <= 1'b0;
        end else if (!soft_reset_n) begin
            state_r      <= IDLE;
            grant_r      <= SRC_NONE;
            id_idx_r     <= 2'd0;
            last_r       <= 1'b0;
            id_pending_r <= 1'b0;
            byte_count   <= '0;
            tx_data      <= 8'h00;
            tx_start     <= 1'b0;
            meta_ready   <= 1'b0;
            data_ready   <= 1'b0;
            arb_busy     <= 1'b0;
        end else begin
            state_r      <= state_s;
            grant_r      <= grant_s;
            id_idx_r     <= id_idx_s;
            last_r       <= last_s;
            id_pending_r <= id_pending_s;
            byte_count   <= byte_count_s;
            tx_data      <= tx_data_s;
            tx_start     <= tx_start_s;
            meta_ready   <= meta_ready_s;
            data_ready   <= data_ready_s;
            arb_busy     <= (state_s != IDLE);
        end
    end

    assign grant = grant_r;

    uart_byte_pacer #(
        .BUSY_TIMEOUT (BUSY_TIMEOUT)
    ) u_pacer (
        .system_clock (system_clock),
        .ext_reset_n  (ext_reset_n),
        .soft_reset_n (soft_reset_n),
        .start        (tx_start),
        .tx_busy      (tx_busy),
        .done         (pacer_done_s),
        .timeout_err  (timeout_err)
    );

endmodule
